// File: rtl/reg_bus_controller_pkg.sv
// Shared state and operation encodings for the register bus controller.
package reg_bus_controller_pkg;

  typedef enum logic [2:0] {
    BUS_IDLE   = 3'd0,
    BUS_SNOOP  = 3'd1,
    BUS_MEM_RD = 3'd2,
    BUS_MEM_WR = 3'd3,
    BUS_DONE   = 3'd4
  } bus_state_e;

  typedef enum logic {
    BUS_OP_READ  = 1'b0,
    BUS_OP_WRITE = 1'b1
  } bus_op_e;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/reg_bus_controller_watchdog.sv
// Saturating 8-bit access watchdog; expired flags the cycle whose count reaches TMO_CYC.
module reg_bus_controller_watchdog
  import reg_bus_controller_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TMO_CYC - 1);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {TMO_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expiry looks one increment ahead so the strobe lasts exactly TMO_CYC cycles.
  assign expired = en && (cnt_q >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_bus_controller.sv
// Shared-bus controller: accepts one register read/write, runs it on the memory
// port with an optional snoop window, then echoes address and data for one cycle.
module reg_bus_controller
  import reg_bus_controller_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_q,
  input  logic              write_q,
  input  logic              halt_q,
  input  logic              rw_halt,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_oe,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  output logic              is_bus_busy,
  output logic              read_dn,
  output logic              write_dn,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  bus_state_e        state_q, state_d;
  bus_op_e           op_q, op_d;
  logic              tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              in_mem;
  logic              wd_expired;

  assign in_mem = (state_q == BUS_MEM_RD) || (state_q == BUS_MEM_WR);

  reg_bus_controller_watchdog #(
    .TMO_CYC (TMO_CYC)
  ) u_bus_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_mem),
    .en      (in_mem && !mem_ack),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    data_d      = data_q;
    addr_o      = '0;
    addr_oe     = 1'b0;
    data_o      = '0;
    data_oe     = 1'b0;
    is_bus_busy = 1'b0;
    read_dn     = 1'b0;
    write_dn    = 1'b0;
    bus_err     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;

    unique case (state_q)
      BUS_IDLE: begin
        tmo_d = 1'b0;
        // A simultaneous read is dropped in favour of the write.
        if (write_q) begin
          op_d    = BUS_OP_WRITE;
          addr_d  = addr_i;
          data_d  = data_i;
          state_d = BUS_MEM_WR;
        end else if (read_q) begin
          op_d    = BUS_OP_READ;
          addr_d  = addr_i;
          data_d  = data_i;
          state_d = halt_q ? BUS_SNOOP : BUS_MEM_RD;
        end
      end
      BUS_SNOOP: begin
        // Only a definite 1 cancels; an undriven rw_halt lets the read proceed.
        state_d = (rw_halt === 1'b1) ? BUS_IDLE : BUS_MEM_RD;
      end
      BUS_MEM_RD: begin
        is_bus_busy = 1'b1;
        mem_addr    = addr_q;
        mem_wdata   = data_q;
        mem_rd      = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = BUS_DONE;
        end else if (wd_expired) begin
          data_d  = '0;
          tmo_d   = 1'b1;
          state_d = BUS_DONE;
        end
      end
      BUS_MEM_WR: begin
        is_bus_busy = 1'b1;
        mem_addr    = addr_q;
        mem_wdata   = data_q;
        mem_wr      = 1'b1;
        if (mem_ack) begin
          state_d = BUS_DONE;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = BUS_DONE;
        end
      end
      BUS_DONE: begin
        is_bus_busy = 1'b1;
        addr_oe     = 1'b1;
        addr_o      = addr_q;
        data_oe     = 1'b1;
        data_o      = data_q;
        read_dn     = (op_q == BUS_OP_READ);
        write_dn    = (op_q == BUS_OP_WRITE);
        bus_err     = tmo_q;
        state_d     = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      op_q    <= BUS_OP_READ;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
    end
  end

  // Address/data are only visible through state-gated outputs, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_reg_bus_controller.sv
// Directed bench for reg_bus_controller with a completion scoreboard.
module tb_reg_bus_controller;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_q, write_q, halt_q, rw_halt, mem_ack;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] data_i, mem_rdata;
  logic [AW-1:0] addr_o, mem_addr;
  logic [DW-1:0] data_o, mem_wdata;
  logic          addr_oe, data_oe, is_bus_busy, read_dn, write_dn, bus_err;
  logic          mem_rd, mem_wr;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  reg_bus_controller #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TMO_CYC (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_q      (read_q),
    .write_q     (write_q),
    .halt_q      (halt_q),
    .rw_halt     (rw_halt),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .addr_o      (addr_o),
    .addr_oe     (addr_oe),
    .data_o      (data_o),
    .data_oe     (data_oe),
    .is_bus_busy (is_bus_busy),
    .read_dn     (read_dn),
    .write_dn    (write_dn),
    .bus_err     (bus_err),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic err);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d; e.err = err;
    sb.push_back(e);
  endtask

  // Completion monitor: every dn pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (read_dn || write_dn) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_dn observed=%0d expected=nonzero", sb.size());
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_write_dn", {31'd0, write_dn}, {31'd0, e.wr});
        chk("sb_read_dn", {31'd0, read_dn}, {31'd0, !e.wr});
        chk("sb_addr_o", addr_o, e.addr);
        chk("sb_data_o", data_o, e.data);
        chk("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        chk("sb_oe", {30'd0, addr_oe, data_oe}, 32'd3);
        chk("sb_busy", {31'd0, is_bus_busy}, 32'd1);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; read_q = 1'b0; write_q = 1'b0; halt_q = 1'b0; rw_halt = 1'b0;
    mem_ack = 1'b0; addr_i = '0; data_i = '0; mem_rdata = '0;
    repeat (3) step();
    chk("rst_strobes", {29'd0, mem_rd, mem_wr, is_bus_busy}, 32'd0);
    chk("rst_dn", {28'd0, read_dn, write_dn, bus_err, addr_oe}, 32'd0);
    chk("rst_addr_o", addr_o, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait read.
    addr_i = 32'h5; read_q = 1'b1; push(1'b0, 32'h5, 32'hDEADBEEF, 1'b0);
    step();
    read_q = 1'b0;
    chk("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h5);
    chk("rd_busy_t1", {31'd0, is_bus_busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rd_dn_t2", {31'd0, read_dn}, 32'd1);
    chk("rd_strobe_dropped", {31'd0, mem_rd}, 32'd0);
    step();
    chk("rd_busy_t3", {31'd0, is_bus_busy}, 32'd0);
    chk("rd_oe_t3", {30'd0, addr_oe, data_oe}, 32'd0);

    // Write with three wait cycles.
    addr_i = 32'h3; data_i = 32'h12345678; write_q = 1'b1;
    push(1'b1, 32'h3, 32'h12345678, 1'b0);
    step();
    write_q = 1'b0; data_i = '0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_mem_wr_wait", {31'd0, mem_wr}, 32'd1);
      chk("wr_mem_wdata", mem_wdata, 32'h12345678);
      step();
    end
    chk("wr_mem_wr_last", {31'd0, mem_wr}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("wr_dn", {31'd0, write_dn}, 32'd1);
    chk("wr_strobe_dropped", {31'd0, mem_wr}, 32'd0);
    step();
    chk("wr_dn_one_cycle", {31'd0, write_dn}, 32'd0);

    // Snoop cancelled by a pending write elsewhere.
    addr_i = 32'h7; read_q = 1'b1; halt_q = 1'b1;
    step();
    read_q = 1'b0; halt_q = 1'b0;
    chk("snp_busy_window", {31'd0, is_bus_busy}, 32'd0);
    chk("snp_no_mem_rd", {31'd0, mem_rd}, 32'd0);
    rw_halt = 1'b1;
    step();
    rw_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("snp_cancel_idle", {30'd0, mem_rd, is_bus_busy}, 32'd0);
      step();
    end

    // Snoop passes: read completes one cycle later than usual.
    addr_i = 32'h9; read_q = 1'b1; halt_q = 1'b1; push(1'b0, 32'h9, 32'hCAFEF00D, 1'b0);
    step();
    read_q = 1'b0; halt_q = 1'b0;
    chk("snp2_window", {30'd0, mem_rd, is_bus_busy}, 32'd0);
    step();
    chk("snp2_mem_rd", {31'd0, mem_rd}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    chk("snp2_dn_t3", {31'd0, read_dn}, 32'd1);
    step();

    // Timeout on a read: strobe for TMO_CYC cycles, error completion with zero data.
    addr_i = 32'hA; data_i = 32'h55; mem_rdata = 32'hFFFF0000; read_q = 1'b1;
    push(1'b0, 32'hA, 32'h0, 1'b1);
    step();
    read_q = 1'b0; data_i = '0;
    n = 0;
    for (int i = 0; i < 10 && mem_rd; i++) begin
      n++;
      step();
    end
    chk("tmo_strobe_cycles", n, 32'd4);
    chk("tmo_dn_err", {30'd0, read_dn, bus_err}, 32'd3);
    step();
    chk("tmo_err_pulse", {31'd0, bus_err}, 32'd0);

    // Read and write in the same cycle: write wins.
    addr_i = 32'h11; data_i = 32'hA5A5A5A5; read_q = 1'b1; write_q = 1'b1;
    push(1'b1, 32'h11, 32'hA5A5A5A5, 1'b0);
    step();
    read_q = 1'b0; write_q = 1'b0;
    chk("col_strobes", {30'd0, mem_rd, mem_wr}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    // Back-to-back from the first IDLE cycle, with a request ignored mid-access.
    addr_i = 32'h20; read_q = 1'b1; push(1'b0, 32'h20, 32'h1111, 1'b0);
    step();
    chk("b2b_mem_rd", {31'd0, mem_rd}, 32'd1);
    addr_i = 32'h30;
    step();
    read_q = 1'b0;
    chk("ign_mem_addr", mem_addr, 32'h20);
    mem_ack = 1'b1; mem_rdata = 32'h1111;
    step();
    mem_ack = 1'b0;
    repeat (3) step();
    chk("ign_idle", {31'd0, is_bus_busy}, 32'd0);

    // Reset mid-access drops it; a late ack is ignored.
    addr_i = 32'h40; read_q = 1'b1;
    step();
    read_q = 1'b0;
    chk("rmid_mem_rd", {31'd0, mem_rd}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_outputs", {26'd0, mem_rd, mem_wr, is_bus_busy, addr_oe, data_oe, read_dn}, 32'd0);
    chk("rmid_mem_addr", mem_addr, 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (2) step();
    chk("rmid_late_ack", {29'd0, mem_rd, is_bus_busy, read_dn}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
